// File: rtl/lsu_dmem_if.sv
// Bus bundle for the load/store unit: execute-side request, memory
// request/grant/rvalid channel, and the writeback response.
interface lsu_dmem_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [RD_W-1:0] req_rd;

    logic            mem_req;
    logic            mem_gnt;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic [RD_W-1:0] rsp_rd;
    logic            rsp_err;

    // The LSU masters the memory channel and answers the execute stage.
    modport master (
        input  req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd,
        output req_ready,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd,
        input  req_ready,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );
endinterface

// File: rtl/lsu_dmem.sv
// Single-outstanding load/store unit: checks alignment/legality, runs one
// req/gnt/rvalid memory transaction and returns an extended load result.
module lsu_dmem #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_dmem_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    state_t state, state_nx;

    logic            mem_req_q,   mem_req_nx;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_nx;
    logic            mem_we_q,    mem_we_nx;
    logic [3:0]      mem_be_q,    mem_be_nx;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_nx;
    logic            rsp_valid_q, rsp_valid_nx;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_nx;
    logic [RD_W-1:0] rsp_rd_q,    rsp_rd_nx;
    logic            rsp_err_q,   rsp_err_nx;

    logic [2:0]      lat_f3,  lat_f3_nx;
    logic [1:0]      lat_lo,  lat_lo_nx;
    logic [RD_W-1:0] lat_rd,  lat_rd_nx;
    logic            lat_we,  lat_we_nx;

    logic            req_bad;
    logic [3:0]      be_dec;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_err   = rsp_err_q;

    // Request-side decode: anything illegal or misaligned never reaches memory.
    always_comb begin
        req_bad   = 1'b0;
        be_dec    = 4'b1111;
        wdata_rep = bus.req_wdata;
        if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 ||
            (bus.req_we && bus.req_funct3[2]))
            req_bad = 1'b1;
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            req_bad = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << bus.req_addr[1:0];
                wdata_rep = {(XLEN/8){bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_dec    = 4'b0011 << bus.req_addr[1:0];
                wdata_rep = {(XLEN/16){bus.req_wdata[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        lane     = bus.mem_rdata >> {lat_lo, 3'b000};
        load_ext = lane;
        case (lat_f3)
            3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state logic; every registered output defaults to holding its value
    // except rsp_valid, which is a one-cycle pulse.
    always_comb begin
        state_nx     = state;
        mem_req_nx   = mem_req_q;
        mem_addr_nx  = mem_addr_q;
        mem_we_nx    = mem_we_q;
        mem_be_nx    = mem_be_q;
        mem_wdata_nx = mem_wdata_q;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = rsp_rdata_q;
        rsp_rd_nx    = rsp_rd_q;
        rsp_err_nx   = rsp_err_q;
        lat_f3_nx    = lat_f3;
        lat_lo_nx    = lat_lo;
        lat_rd_nx    = lat_rd;
        lat_we_nx    = lat_we;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_f3_nx = bus.req_funct3;
                    lat_lo_nx = bus.req_addr[1:0];
                    lat_rd_nx = bus.req_rd;
                    lat_we_nx = bus.req_we;
                    if (req_bad) begin
                        state_nx     = RSP;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = '0;
                        rsp_rd_nx    = bus.req_rd;
                    end else begin
                        state_nx     = REQ;
                        mem_req_nx   = 1'b1;
                        mem_addr_nx  = {bus.req_addr[XLEN-1:2], 2'b00};
                        mem_we_nx    = bus.req_we;
                        mem_be_nx    = be_dec;
                        mem_wdata_nx = wdata_rep;
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    mem_req_nx = 1'b0;
                    if (lat_we) begin
                        state_nx     = RSP;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b0;
                        rsp_rdata_nx = '0;
                        rsp_rd_nx    = lat_rd;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nx     = RSP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b0;
                    rsp_rdata_nx = load_ext;
                    rsp_rd_nx    = lat_rd;
                end
            end
            RSP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            lat_f3      <= 3'b0;
            lat_lo      <= 2'b0;
            lat_rd      <= '0;
            lat_we      <= 1'b0;
        end else begin
            state       <= state_nx;
            mem_req_q   <= mem_req_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_we_q    <= mem_we_nx;
            mem_be_q    <= mem_be_nx;
            mem_wdata_q <= mem_wdata_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_rdata_q <= rsp_rdata_nx;
            rsp_rd_q    <= rsp_rd_nx;
            rsp_err_q   <= rsp_err_nx;
            lat_f3      <= lat_f3_nx;
            lat_lo      <= lat_lo_nx;
            lat_rd      <= lat_rd_nx;
            lat_we      <= lat_we_nx;
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: hand-computed vectors covering loads, stores,
// errors, stalls, back-to-back issue and reset in mid-transaction.
module tb_lsu_dmem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    lsu_dmem_if #(.XLEN(32), .RD_W(5)) bus ();

    lsu_dmem #(.XLEN(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction, driven and checked at negedges; returns in the
    // IDLE cycle after the response so the next call issues back-to-back.
    task automatic applyStimulus(input string tag,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic [2:0] f3,
                                 input logic [4:0] rd,
                                 input int gntWait, input int rvWait,
                                 input logic [31:0] rdata,
                                 input logic expErr, input logic [3:0] expBe,
                                 input logic [31:0] expWdata,
                                 input logic [31:0] expRdata);
        int acc;
        checkOutput({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        acc = cyc;
        nextCycle();
        bus.req_valid = 1'b0;
        if (expErr) begin
            checkOutput({tag, "_nomemreq"}, {31'b0, bus.mem_req}, 32'd0);
            checkOutput({tag, "_rspvalid"}, {31'b0, bus.rsp_valid}, 32'd1);
            checkOutput({tag, "_err"}, {31'b0, bus.rsp_err}, 32'd1);
            checkOutput({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
            checkOutput({tag, "_rd"}, {27'b0, bus.rsp_rd}, {27'b0, rd});
            checkOutput({tag, "_lat"}, cyc - acc, 32'd1);
        end else begin
            checkOutput({tag, "_memreq"}, {31'b0, bus.mem_req}, 32'd1);
            checkOutput({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            checkOutput({tag, "_be"}, {28'b0, bus.mem_be}, {28'b0, expBe});
            checkOutput({tag, "_we"}, {31'b0, bus.mem_we}, {31'b0, we});
            if (we)
                checkOutput({tag, "_wdata"}, bus.mem_wdata, expWdata);
            for (int i = 0; i < gntWait; i++) begin
                nextCycle();
                checkOutput({tag, "_hold_req"}, {31'b0, bus.mem_req}, 32'd1);
                checkOutput({tag, "_hold_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                checkOutput({tag, "_hold_be"}, {28'b0, bus.mem_be}, {28'b0, expBe});
            end
            bus.mem_gnt = 1'b1;
            nextCycle();
            bus.mem_gnt = 1'b0;
            checkOutput({tag, "_reqdrop"}, {31'b0, bus.mem_req}, 32'd0);
            if (!we) begin
                for (int i = 0; i < rvWait; i++) begin
                    checkOutput({tag, "_norsp_wait"}, {31'b0, bus.rsp_valid}, 32'd0);
                    nextCycle();
                end
                checkOutput({tag, "_norsp_wait"}, {31'b0, bus.rsp_valid}, 32'd0);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                nextCycle();
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'h0;
            end
            checkOutput({tag, "_rspvalid"}, {31'b0, bus.rsp_valid}, 32'd1);
            checkOutput({tag, "_err"}, {31'b0, bus.rsp_err}, 32'd0);
            checkOutput({tag, "_rdata"}, bus.rsp_rdata, expRdata);
            checkOutput({tag, "_rd"}, {27'b0, bus.rsp_rd}, {27'b0, rd});
            checkOutput({tag, "_lat"}, cyc - acc,
                        we ? 32'(2 + gntWait) : 32'(3 + gntWait + rvWait));
        end
        nextCycle();
        checkOutput({tag, "_pulse"}, {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, bus.req_ready}, 32'd1);
        checkOutput({tag, "_rdhold"}, {27'b0, bus.rsp_rd}, {27'b0, rd});
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_rd     = 5'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        rst_n = 1'b0;
        repeat (3) nextCycle();
        rst_n = 1'b1;
        checkOutput("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rst_memreq", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst_rspvalid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("rst_be", {28'b0, bus.mem_be}, 32'd0);
        nextCycle();

        applyStimulus("lw", 32'h100, 32'h0, 1'b0, 3'b010, 5'd5, 0, 0,
                      32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
        applyStimulus("lb", 32'h203, 32'h0, 1'b0, 3'b000, 5'd6, 0, 0,
                      32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
        applyStimulus("lbu", 32'h203, 32'h0, 1'b0, 3'b100, 5'd7, 0, 0,
                      32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'h00000080);
        applyStimulus("sh", 32'h302, 32'h1234ABCD, 1'b1, 3'b001, 5'd8, 3, 0,
                      32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
        applyStimulus("lw_mis", 32'h101, 32'h0, 1'b0, 3'b010, 5'd9, 0, 0,
                      32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus("sbu_ill", 32'h40, 32'h55, 1'b1, 3'b100, 5'd10, 0, 0,
                      32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus("f3_ill", 32'h40, 32'h0, 1'b0, 3'b011, 5'd11, 0, 0,
                      32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus("lh_mis", 32'h45, 32'h0, 1'b0, 3'b001, 5'd12, 0, 0,
                      32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus("b2b_sb", 32'h11, 32'h000000A5, 1'b1, 3'b000, 5'd13, 0, 0,
                      32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        applyStimulus("b2b_lhu", 32'h2, 32'h0, 1'b0, 3'b101, 5'd14, 0, 0,
                      32'hBEEF0000, 1'b0, 4'b1100, 32'h0, 32'h0000BEEF);
        applyStimulus("lh_stall", 32'h6, 32'h0, 1'b0, 3'b001, 5'd15, 1, 2,
                      32'h80011234, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001);
        applyStimulus("sw", 32'h400, 32'hCAFEF00D, 1'b1, 3'b010, 5'd16, 0, 0,
                      32'h0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0);
        applyStimulus("lbu_b1", 32'h501, 32'h0, 1'b0, 3'b100, 5'd17, 0, 1,
                      32'h1122C344, 1'b0, 4'b0010, 32'h0, 32'h000000C3);

        // Abandon a load in WAIT, then offer stray rvalid/gnt while idle.
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h600;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_rd     = 5'd18;
        nextCycle();
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        nextCycle();
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        checkOutput("mrst_memreq", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("mrst_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        nextCycle();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;
        checkOutput("mrst_norsp", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("mrst_noreq", {31'b0, bus.mem_req}, 32'd0);
        nextCycle();
        checkOutput("mrst_norsp2", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("mrst_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("mrst_rd", {27'b0, bus.rsp_rd}, 32'd0);
        checkOutput("mrst_be", {28'b0, bus.mem_be}, 32'd0);
        checkOutput("mrst_addr", bus.mem_addr, 32'd0);
        checkOutput("mrst_ready2", {31'b0, bus.req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
